// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types and address helpers for data_memory
package data_memory_pkg;

    localparam int unsigned MAX_ADDR_W = 32;
    localparam int unsigned MAX_DATA_W = 128;
    localparam int unsigned MAX_BEN_W  = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Request as captured at acceptance; fields are sized for the widest
    // supported configuration and zero-extended by the top.
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_BEN_W-1:0]  ben;
        logic [MAX_DATA_W-1:0] wdata;
        logic                  is_write;
    } mem_req_t;

    function automatic logic [MAX_ADDR_W-1:0] word_index(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           lane_bits
    );
        return addr >> lane_bits;
    endfunction

    // A faulted access still completes, but touches neither array nor ReadData.
    function automatic logic access_fault(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           lane_bits,
        input int unsigned           depth,
        input logic                  conflict
    );
        logic [MAX_ADDR_W-1:0] lane_mask;
        logic                  misaligned;
        logic                  out_of_range;
        lane_mask    = (MAX_ADDR_W'(1) << lane_bits) - MAX_ADDR_W'(1);
        misaligned   = (addr & lane_mask) != '0;
        out_of_range = word_index(addr, lane_bits) >= MAX_ADDR_W'(depth);
        return misaligned | out_of_range | conflict;
    endfunction

endpackage

// File: rtl/data_memory_mem_array.sv
// rtl/data_memory_mem_array.sv - word storage with byte-lane write and registered read
module data_memory_mem_array #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 10
) (
    input  logic                clk,
    input  logic [DATA_W/8-1:0] wr_ben,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write and registered read; no reset so the array maps to block RAM
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DATA_W / 8); i++) begin
            if (wr_ben[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-organised data memory with wait states and error response
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic [ADDR_W-1:0]   Address,
    input  logic                ReadEn,
    input  logic                WriteEn,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic [DATA_W-1:0]   WriteData,
    output logic [DATA_W-1:0]   ReadData,
    output logic                Ready,
    output logic                Busy,
    output logic                Error
);

    localparam int unsigned BEN_W     = DATA_W / 8;
    localparam int unsigned LANE_BITS = $clog2(BEN_W);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    mem_req_t   req_q, req_d;
    logic       fault_q, fault_d;

    logic              req_valid;
    logic [BEN_W-1:0]  ram_wr_ben;
    logic              ram_rd_en;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign req_valid = ReadEn | WriteEn;

    // Next state: accept in IDLE, count down wait states, single-cycle response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.addr     = MAX_ADDR_W'(Address);
                    req_d.ben      = MAX_BEN_W'(ByteEn);
                    req_d.wdata    = MAX_DATA_W'(WriteData);
                    req_d.is_write = WriteEn;
                    fault_d        = access_fault(MAX_ADDR_W'(Address), LANE_BITS,
                                                  DEPTH, ReadEn & WriteEn);
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array access on the edge entering RESP; req_d/fault_d already hold the
    // request for that edge whether it was just captured or has been waiting.
    // Held off during reset so an aborted write never reaches the array.
    always_comb begin
        ram_wr_ben = '0;
        ram_rd_en  = 1'b0;
        ram_idx    = IDX_W'(word_index(req_d.addr, LANE_BITS));
        ram_wdata  = req_d.wdata[DATA_W-1:0];
        if (nReset && (state_d == RESP) && !fault_d) begin
            if (req_d.is_write) begin
                ram_wr_ben = req_d.ben[BEN_W-1:0];
            end else begin
                ram_rd_en = 1'b1;
            end
        end
    end

    // State, wait counter and captured request; the array itself is not reset
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    data_memory_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk    (Clock),
        .wr_ben (ram_wr_ben),
        .rd_en  (ram_rd_en),
        .idx    (ram_idx),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

    assign Busy     = (state_q != IDLE);
    assign Ready    = (state_q == RESP);
    assign Error    = Ready & fault_q;
    assign ReadData = (Ready && !fault_q && !req_q.is_write) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory
module tb_data_memory;

    localparam int WS_A = 0;
    localparam int WS_B = 3;

    logic        clk = 1'b0;
    logic        rstn [2];
    logic [15:0] addr [2];
    logic        ren  [2];
    logic        wen  [2];
    logic [3:0]  ben  [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        rdy  [2];
    logic        bsy  [2];
    logic        err  [2];

    int errors = 0;
    int checks = 0;
    int acc     [2] = '{0, 0};
    int rdy_cnt [2] = '{0, 0};
    logic [31:0] mdl [2][1024];
    logic [31:0] got;

    always #5 clk = ~clk;

    data_memory #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(WS_A)) dut_a (
        .Clock(clk), .nReset(rstn[0]), .Address(addr[0]), .ReadEn(ren[0]),
        .WriteEn(wen[0]), .ByteEn(ben[0]), .WriteData(wdat[0]),
        .ReadData(rdat[0]), .Ready(rdy[0]), .Busy(bsy[0]), .Error(err[0])
    );

    data_memory #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(WS_B)) dut_b (
        .Clock(clk), .nReset(rstn[1]), .Address(addr[1]), .ReadEn(ren[1]),
        .WriteEn(wen[1]), .ByteEn(ben[1]), .WriteData(wdat[1]),
        .ReadData(rdat[1]), .Ready(rdy[1]), .Busy(bsy[1]), .Error(err[1])
    );

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdy[d] === 1'b1) rdy_cnt[d]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic bit exp_fault(input logic [15:0] a, input logic re, input logic we);
        int unsigned ai;
        ai = 32'(a);
        return ((ai % 4) != 0) || ((ai / 4) >= 1024) || (re && we);
    endfunction

    // One complete access, started just after a negedge; checks every cycle
    // up to and including the IDLE cycle that follows Ready.
    task automatic access(input int d, input logic [15:0] a, input logic re, input logic we,
                          input logic [3:0] be, input logic [31:0] wd, output logic [31:0] rd);
        int          n;
        int          lat;
        int          w;
        bit          flt;
        logic [31:0] exp_rd;
        rd     = '0;
        lat    = (d == 0) ? WS_A + 1 : WS_B + 1;
        w      = int'(a) / 4;
        flt    = exp_fault(a, re, we);
        exp_rd = '0;
        if (!flt && !we) exp_rd = mdl[d][w];
        addr[d] = a; ren[d] = re; wen[d] = we; ben[d] = be; wdat[d] = wd;
        n = 0;
        while (bsy[d] !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk1($sformatf("d%0d_accept_wait", d), (n < 40), 1'b1);
        @(posedge clk);
        acc[d]++;
        @(negedge clk);
        ren[d] = 1'b0; wen[d] = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            if (c < lat) begin
                chk1($sformatf("d%0d_ready_early_c%0d", d, c), rdy[d], 1'b0);
                chk1($sformatf("d%0d_busy_wait_c%0d", d, c), bsy[d], 1'b1);
            end else begin
                chk1($sformatf("d%0d_ready_a%h", d, a), rdy[d], 1'b1);
                chk1($sformatf("d%0d_error_a%h", d, a), err[d], flt);
                chk1($sformatf("d%0d_busy_resp", d), bsy[d], 1'b1);
                if (!we || flt) chk32($sformatf("d%0d_rdata_a%h", d, a), rdat[d], exp_rd);
                rd = rdat[d];
            end
        end
        @(negedge clk);
        chk1($sformatf("d%0d_ready_after", d), rdy[d], 1'b0);
        chk1($sformatf("d%0d_busy_after", d), bsy[d], 1'b0);
        chk32($sformatf("d%0d_rdata_idle", d), rdat[d], 32'h0);
        if (we && !flt) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mdl[d][w][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; addr[d] = '0; ren[d] = 1'b0; wen[d] = 1'b0;
            ben[d] = '0; wdat[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("d%0d_reset_ready", d), rdy[d], 1'b0);
            chk1($sformatf("d%0d_reset_busy", d), bsy[d], 1'b0);
            chk1($sformatf("d%0d_reset_error", d), err[d], 1'b0);
            chk32($sformatf("d%0d_reset_rdata", d), rdat[d], 32'h0);
        end
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        @(negedge clk);

        // Zero wait states: basic write/read, byte lanes
        access(0, 16'h0010, 1'b0, 1'b1, 4'hF, 32'h12345678, got);
        access(0, 16'h0010, 1'b1, 1'b0, 4'hF, 32'h0, got);
        chk32("basic_read", got, 32'h12345678);
        access(0, 16'h0010, 1'b0, 1'b1, 4'b0101, 32'hAABBCCDD, got);
        access(0, 16'h0010, 1'b1, 1'b0, 4'hF, 32'h0, got);
        chk32("lane_merge", got, 32'h12BB56DD);

        // Faults: out of range, misaligned, conflicting enables; ByteEn=0 no-op
        access(0, 16'h0000, 1'b0, 1'b1, 4'hF, 32'hCAFE0001, got);
        access(0, 16'h1000, 1'b1, 1'b0, 4'hF, 32'h0, got);
        access(0, 16'h1000, 1'b0, 1'b1, 4'hF, 32'hFFFFFFFF, got);
        access(0, 16'h0000, 1'b1, 1'b0, 4'hF, 32'h0, got);
        chk32("oor_no_alias", got, 32'hCAFE0001);
        access(0, 16'h0002, 1'b1, 1'b0, 4'hF, 32'h0, got);
        access(0, 16'h0002, 1'b0, 1'b1, 4'hF, 32'h55555555, got);
        access(0, 16'h0000, 1'b1, 1'b0, 4'hF, 32'h0, got);
        chk32("misaligned_no_write", got, 32'hCAFE0001);
        access(0, 16'h0010, 1'b1, 1'b1, 4'hF, 32'h0BADBEEF, got);
        access(0, 16'h0010, 1'b1, 1'b0, 4'hF, 32'h0, got);
        chk32("conflict_no_write", got, 32'h12BB56DD);
        access(0, 16'h0010, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, got);
        access(0, 16'h0010, 1'b1, 1'b0, 4'hF, 32'h0, got);
        chk32("ben_zero_noop", got, 32'h12BB56DD);

        // Three wait states: latency and a request held through Busy
        access(1, 16'h0010, 1'b0, 1'b1, 4'hF, 32'h87654321, got);
        addr[1] = 16'h0010; ren[1] = 1'b1; wen[1] = 1'b0; ben[1] = 4'hF;
        @(posedge clk);
        acc[1]++;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk1($sformatf("held_busy_c%0d", c), bsy[1], 1'b1);
            chk1($sformatf("held_ready_c%0d", c), rdy[1], (c == 4));
        end
        chk32("held_rdata_first", rdat[1], 32'h87654321);
        @(negedge clk);
        chk1("held_idle_gap_busy", bsy[1], 1'b0);
        chk1("held_idle_gap_ready", rdy[1], 1'b0);
        @(negedge clk);
        chk1("held_reaccepted", bsy[1], 1'b1);
        acc[1]++;
        ren[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk1("held_second_ready", rdy[1], 1'b1);
        chk32("held_rdata_second", rdat[1], 32'h87654321);
        @(negedge clk);
        chk1("held_done_busy", bsy[1], 1'b0);

        // Known contents for the random phase
        for (int w = 0; w < 16; w++) begin
            for (int d = 0; d < 2; d++) begin
                access(d, 16'(w * 4), 1'b0, 1'b1, 4'hF, $urandom, got);
            end
        end

        // Reset two cycles after accepting a write: nothing may be committed
        addr[1] = 16'h0020; ren[1] = 1'b0; wen[1] = 1'b1; ben[1] = 4'hF;
        wdat[1] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        wen[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk1("busy_before_reset", bsy[1], 1'b1);
        rstn[1] = 1'b0;
        #1;
        chk1("midreset_ready", rdy[1], 1'b0);
        chk1("midreset_busy", bsy[1], 1'b0);
        chk1("midreset_error", err[1], 1'b0);
        chk32("midreset_rdata", rdat[1], 32'h0);
        @(negedge clk);
        rstn[1] = 1'b1;
        @(negedge clk);
        access(1, 16'h0020, 1'b1, 1'b0, 4'hF, 32'h0, got);
        chk1("midreset_not_committed", (got !== 32'hDEADBEEF), 1'b1);

        // Random back-to-back accesses against the model
        for (int k = 0; k < 100; k++) begin
            for (int d = 0; d < 2; d++) begin
                int          w;
                int          op;
                logic [3:0]  be;
                w  = int'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) w = 1024 + int'($urandom_range(0, 15));
                op = int'($urandom_range(0, 2));
                be = (op == 2) ? 4'($urandom_range(0, 15)) : 4'hF;
                access(d, 16'(w * 4), (op == 0), (op != 0), be, $urandom, got);
            end
        end

        @(negedge clk);
        #1;
        chk32("ready_count_d0", 32'(rdy_cnt[0]), 32'(acc[0]));
        chk32("ready_count_d1", 32'(rdy_cnt[1]), 32'(acc[1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Parametrised word-organised data memory for the processor bench and for FPGA builds.
- Successor to the fixed single-cycle bench memory. Adds configurable depth and width, byte write enables, programmable wait states with a Ready/Busy handshake, and an error response for misaligned, out-of-range or conflicting accesses.
- Connects to the PROCESSOR MemAddr/MemData/WriteData/MemRead/MemWrite port group.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 32: data width; must be a multiple of 8.
- DEPTH, 1024: number of words; must satisfy DEPTH*(DATA_W/8) <= 2**ADDR_W.
- WAIT_STATES, 0: extra cycles inserted before Ready (range 0..15).

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- Address  input  ADDR_W  byte address, word aligned.
- ReadEn  input  1  read request.
- WriteEn  input  1  write request.
- ByteEn  input  DATA_W/8  byte lane write mask; bit i controls bits [8i+7:8i].
- WriteData  input  DATA_W  write data.
- ReadData  output  DATA_W  read data; valid only while Ready=1.
- Ready  output  1  one-cycle completion pulse.
- Busy  output  1  a request is in flight; new requests are ignored.
- Error  output  1  one-cycle pulse coincident with Ready for a faulted access.

Behaviour:
- Reset: one clock, asynchronous, active-low. Asserting nReset forces state IDLE, ReadData=0, Ready=0, Busy=0, Error=0, and clears the wait counter. Array contents are retained through reset. Reset mid-operation aborts the access; a pending write is not committed.
- Word index = Address[ADDR_W-1:log2(DATA_W/8)]. A request is misaligned if the low log2(DATA_W/8) address bits are nonzero. It is out of range if word index >= DEPTH.
- State machine: IDLE, WAIT, RESP.
- IDLE: at a rising edge with ReadEn|WriteEn=1, capture Address, ByteEn, WriteData and the operation type, and set Busy=1.
  - WAIT_STATES=0: go to RESP.
  - Otherwise: load counter=WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. Go to RESP on the edge where counter==0. Request inputs are ignored.
- RESP:
  - Ready=1 for exactly one cycle.
  - Write: lanes with ByteEn=1 are committed at the edge entering RESP; other lanes are unchanged.
  - Read: ReadData = array[index].
  - Next state is IDLE; Busy=0 in that IDLE cycle.
  - A request present on the edge leaving RESP is NOT accepted. The earliest re-acceptance is one cycle later, giving a minimum 2-cycle (WAIT_STATES+2) repeat interval.
- Latency: acceptance edge to Ready is WAIT_STATES+1 cycles.
- Error cases: misaligned, out of range, or ReadEn&WriteEn both 1 at acceptance. The access still completes with Ready=1 and Error=1. No array update occurs and ReadData=0.
- ByteEn=0 on a write is a legal no-op: Ready=1, Error=0.
- ReadData returns to 0 in every cycle where Ready=0.
- The memory is fully synchronous apart from the reset.

Decomposition:
- Package data_memory_pkg: enum mem_state_t {IDLE, WAIT, RESP} and a struct for the captured request (addr, ben, wdata, is_write).
- Also in the package: function word_index() and function access_fault().
- One sub-module is natural: mem_array (DEPTH x DATA_W storage with synchronous byte-lane write and read port). It keeps the array mappable to block RAM.

Test Plan:
- WAIT_STATES=0: write 32'h12345678 to 16'h0010 with ByteEn=4'hF, then read 16'h0010. Ready must pulse 1 cycle after each acceptance, ReadData=32'h12345678, Error=0.
- Byte lanes: over 32'h12345678, write 32'hAABBCCDD with ByteEn=4'b0101. A read must return 32'h12BB56DD.
- WAIT_STATES=3: read request. Busy=1 for 4 cycles, Ready after exactly 4 cycles; a second request held during Busy is accepted only after the post-RESP IDLE cycle.
- Faults, DEPTH=1024:
  - Address 16'h1000 (out of range): Ready=1, Error=1, ReadData=0, array unchanged.
  - Address 16'h0002 (misaligned): Ready=1, Error=1, ReadData=0.
  - ReadEn=WriteEn=1: Ready=1, Error=1, no write.
- Reset mid-access: with WAIT_STATES=3, assert nReset 2 cycles after accepting a write of 32'hDEADBEEF. All outputs go to 0 immediately, and a later read of that address returns the prior value.
- Back-to-back stress: 100 random aligned accesses checked against a scoreboard model. Ready count must equal accepted-request count.
